// File: rtl/updown_ctrl_fsm.sv
// Direction controller for a bidirectional up/down counter: three-state Moore FSM
// driving one-hot UP_M / Dn_M. Optional macro FSM_STATE_OUT_EN exposes the state register on STATE.
//
// state | meaning
// IDLE  | inactive or trigger conflict; no motion enable
// UP    | counting up; held until reversal, conflict or deactivation
// DOWN  | counting down; held until reversal, conflict or deactivation
module updown_ctrl_fsm (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Ac,
  input  logic       Up_Max,
  input  logic       Dn_Max,
  output logic       UP_M,
  output logic       Dn_M
`ifdef FSM_STATE_OUT_EN
  ,output logic [1:0] STATE
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ac has priority; a held direction survives both triggers low, a conflict drops to IDLE.
  always_comb begin
    state_d = IDLE;
    if (Ac) begin
      case (state_q)
        IDLE: begin
          if (Up_Max && !Dn_Max)      state_d = UP;
          else if (Dn_Max && !Up_Max) state_d = DOWN;
          else                        state_d = IDLE;
        end
        UP: begin
          if (Up_Max && Dn_Max)       state_d = IDLE;
          else if (Dn_Max)            state_d = DOWN;
          else                        state_d = UP;
        end
        DOWN: begin
          if (Up_Max && Dn_Max)       state_d = IDLE;
          else if (Up_Max)            state_d = UP;
          else                        state_d = DOWN;
        end
        default:                      state_d = IDLE;
      endcase
    end
  end

  // Outputs decode the register only; the unused code 2'b11 decodes to neither direction.
  always_comb begin
    UP_M = (state_q == UP);
    Dn_M = (state_q == DOWN);
  end

`ifdef FSM_STATE_OUT_EN
  assign STATE = state_q;
`endif

endmodule

// File: tb/tb_updown_ctrl_fsm.sv
// Scoreboard bench for updown_ctrl_fsm: expectations from a reference transition
// table are queued when inputs are driven and compared one cycle later.
module tb_updown_ctrl_fsm;

  logic CLK = 1'b0;
  logic RST, Ac, Up_Max, Dn_Max;
  logic UP_M, Dn_M;
`ifdef FSM_STATE_OUT_EN
  logic [1:0] STATE;
`endif

  updown_ctrl_fsm dut (
    .CLK(CLK), .RST(RST), .Ac(Ac), .Up_Max(Up_Max), .Dn_Max(Dn_Max),
    .UP_M(UP_M), .Dn_M(Dn_M)
`ifdef FSM_STATE_OUT_EN
    ,.STATE(STATE)
`endif
  );

  always #5 CLK = ~CLK;

  localparam logic [1:0] S_IDLE = 2'b00, S_UP = 2'b01, S_DN = 2'b10;

  typedef struct {
    logic       up;
    logic       dn;
    logic [1:0] st;
    string      tag;
  } exp_t;

  exp_t       sb_q[$];
  logic [1:0] m_st;
  int         n_cmp = 0;
  int         n_err = 0;

  function automatic logic [1:0] ref_next(logic [1:0] s, logic ac, logic up, logic dn);
    if (!ac) return S_IDLE;
    unique case ({up, dn})
      2'b11: return S_IDLE;
      2'b10: return (s == S_IDLE || s == S_UP || s == S_DN) ? S_UP : S_IDLE;
      2'b01: return (s == S_IDLE || s == S_UP || s == S_DN) ? S_DN : S_IDLE;
      default: return (s == S_UP) ? S_UP : ((s == S_DN) ? S_DN : S_IDLE);
    endcase
  endfunction

  task automatic push_exp(input logic [1:0] st, input string tag);
    exp_t e;
    e.up  = (st == S_UP);
    e.dn  = (st == S_DN);
    e.st  = st;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: observed no entry, expected one");
      return;
    end
    e = sb_q.pop_front();
    assert ({UP_M, Dn_M} === {e.up, e.dn}) else begin
      n_err++;
      $error("FAIL %s: UP_M,Dn_M observed %b%b expected %b%b", e.tag, UP_M, Dn_M, e.up, e.dn);
    end
`ifdef FSM_STATE_OUT_EN
    n_cmp++;
    assert (STATE === e.st) else begin
      n_err++;
      $error("FAIL %s_state: STATE observed %b expected %b", e.tag, STATE, e.st);
    end
`endif
  endtask

  task automatic step(input logic ac, input logic up, input logic dn, input string tag);
    @(negedge CLK);
    Ac = ac; Up_Max = up; Dn_Max = dn;
    m_st = ref_next(m_st, ac, up, dn);
    push_exp(m_st, tag);
    @(posedge CLK);
    #1;
    check_out();
  endtask

  initial begin
    RST = 1'b1; Ac = 1'b1; Up_Max = 1'b1; Dn_Max = 1'b0;
    m_st = S_IDLE;
    @(posedge CLK); #1;
    push_exp(S_IDLE, "reset_hold1");
    check_out();
    @(posedge CLK); #1;
    push_exp(S_IDLE, "reset_hold2");
    check_out();

    @(negedge CLK);
    RST = 1'b0; Ac = 1'b0; Up_Max = 1'b0;

    step(1, 0, 1, "down_enter");
    step(1, 0, 1, "down_keep");
    step(1, 0, 0, "down_hold");
    step(0, 0, 0, "deact_idle");
    step(1, 1, 0, "up_enter");
    step(1, 0, 0, "up_hold1");
    step(1, 0, 0, "up_hold2");
    step(1, 0, 0, "up_hold3");
    step(1, 0, 1, "rev_up_dn");
    step(1, 1, 1, "conflict_dn");
    step(1, 1, 1, "idle_both");
    step(1, 0, 0, "idle_none");
    step(1, 0, 1, "down_again");
    step(0, 0, 1, "deact_dn");
    step(0, 1, 0, "off_up");
    step(0, 1, 1, "off_both");
    step(0, 0, 1, "off_dn");
    step(1, 1, 0, "walk_up");
    step(1, 0, 1, "walk_down");
    step(1, 1, 1, "walk_idle");
    step(1, 1, 0, "up_again");
    step(1, 1, 1, "conflict_up");
    step(1, 0, 1, "dn_enter2");
    step(1, 1, 0, "rev_dn_up");

    // Asynchronous reset while in UP, mid-cycle.
    #2;
    RST = 1'b1;
    #1;
    m_st = S_IDLE;
    push_exp(S_IDLE, "async_rst");
    check_out();
    @(negedge CLK);
    RST = 1'b0; Ac = 1'b0; Up_Max = 1'b0; Dn_Max = 1'b0;
    step(1, 0, 0, "post_rst_idle");

    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), "random");
    end

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: observed %0d left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish, expected finish by 20000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/updown_ctrl_fsm.md
Name: updown_ctrl_fsm

Overview:
Three-state Moore controller that drives the direction of a bidirectional up/down counter. It decides the direction from an activation input and two direction-trigger flags. It asserts exactly one of two one-hot direction outputs (UP_M, Dn_M), or neither when idle. The block sits between the counter's limit/trigger logic and the counter's direction-enable inputs.

Parameters:
None. State encoding is fixed: IDLE=2'b00, UP=2'b01, DOWN=2'b10. 2'b11 is illegal.

Ports:
CLK     input   1  system clock; all state updates occur on the rising edge
RST     input   1  asynchronous reset, active-high; forces IDLE immediately
Ac      input   1  activation; 0 = controller inactive, return to IDLE
Up_Max  input   1  up-direction trigger; request to move or keep moving up
Dn_Max  input   1  down-direction trigger; request to move or keep moving down
UP_M    output  1  up-motion enable; 1 only in state UP
Dn_M    output  1  down-motion enable; 1 only in state DOWN

Behaviour:
- Interface: one clock (CLK); reset RST is asynchronous and active-high.
- Reset:
  - RST=1 sets the state to IDLE immediately, without waiting for a clock edge.
  - UP_M=0 and Dn_M=0 while RST is high and after its release.
  - RST release is synchronous in effect: the first transition occurs on the first rising CLK edge with RST=0.
- Moore outputs, decoded from the state register only. Inputs never reach the outputs combinationally.
  - UP_M = (state==UP).
  - Dn_M = (state==DOWN).
  - UP_M and Dn_M are never both 1.
- Latency: inputs are sampled at rising edge N; the new output is visible after edge N, i.e. one cycle.
- Transitions at each rising CLK edge with RST=0:
  - Any state, Ac=0 -> IDLE. Ac has priority over both triggers.
  - IDLE, Ac=1:
    - Dn_Max=1, Up_Max=0 -> DOWN.
    - Up_Max=1, Dn_Max=0 -> UP.
    - Both 0 -> IDLE.
    - Both 1 -> IDLE.
  - UP, Ac=1:
    - Up_Max=1, Dn_Max=0 -> UP.
    - Both 0 -> UP (direction is held).
    - Dn_Max=1, Up_Max=0 -> DOWN (direct reversal, no IDLE cycle).
    - Both 1 -> IDLE (conflict).
  - DOWN, Ac=1:
    - Dn_Max=1, Up_Max=0 -> DOWN.
    - Both 0 -> DOWN (direction is held).
    - Up_Max=1, Dn_Max=0 -> UP (direct reversal).
    - Both 1 -> IDLE (conflict).
- Illegal state 2'b11 (e.g. after an upset) -> IDLE on the next edge; outputs are 0 while in it.
- Reset asserted mid-operation (UP or DOWN) clears the outputs asynchronously; the prior direction is not remembered.
- Implementation structure: separate state register, next-state logic and output decode. Full case coverage with a default branch, no latches.

Optional Feature:
Macro FSM_STATE_OUT_EN.
- Defined:
  - Adds output port STATE, 2 bits, equal to the current state register value.
  - STATE resets to 2'b00 with RST.
  - STATE has the same timing as UP_M and Dn_M.
- Undefined: the STATE port does not exist. All other behaviour is identical.

Test Plan:
- Reset:
  - Drive RST=1 for one cycle with Ac=1 and Up_Max=1 -> UP_M=0, Dn_M=0 throughout.
  - Assert RST=1 asynchronously mid-cycle while in UP -> UP_M drops to 0 before the next edge.
- Down path:
  - After reset, drive Ac=1, Dn_Max=1, Up_Max=0 -> Dn_M=1, UP_M=0 after the first edge.
  - Dn_M is still 1 after two cycles.
- Up path and hold:
  - From IDLE, drive Ac=1, Up_Max=1 for 1 cycle, then Up_Max=0 and Dn_Max=0 for 3 cycles -> UP_M=1 for all 4 cycles.
- Reversal and conflict:
  - In UP, drive Dn_Max=1 -> next cycle Dn_M=1, UP_M=0.
  - Then drive Up_Max=1 and Dn_Max=1 together -> next cycle both outputs 0 (IDLE).
- Deactivation:
  - In DOWN, drive Ac=0 with Dn_Max=1 held -> next cycle Dn_M=0.
  - The block stays IDLE while Ac=0, regardless of the triggers.
- Optional feature (FSM_STATE_OUT_EN defined):
  - Walk IDLE -> UP -> DOWN -> IDLE -> STATE reads 00, 01, 10, 00 in successive cycles.
